// File: rtl/operand_sequencer_pkg.sv
// operand_sequencer_pkg: shared state, opcode, mux-select and ALU encodings
package operand_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, EXEC1, EXEC2, FIN} state_t;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_INC    = 4'h3;
  localparam logic [3:0] OP_CLRA   = 4'h4;
  localparam logic [3:0] OP_MOVAB  = 4'h5;
  localparam logic [3:0] OP_DBL    = 4'h6;
  localparam logic [3:0] OP_CLR2   = 4'h7;
  localparam logic [3:0] OP_ADDINC = 4'h8;
  // Named from operand A's view; sel_b uses the same codes with the two registers swapped
  localparam logic [1:0] SEL_REGA = 2'b00;
  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_REGB = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  typedef struct packed {
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] alu_op;
    logic       load_a;
    logic       load_b;
  } step_t;
  function automatic step_t mk_step(logic [1:0] sa, logic [1:0] sb, logic [1:0] alu, logic la, logic lb);
    return '{sel_a: sa, sel_b: sb, alu_op: alu, load_a: la, load_b: lb};
  endfunction
endpackage

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: instruction handshake, stall and datapath control bundle
interface operand_sequencer_if;
  logic       instr_valid;
  logic [3:0] instr_op;
  logic       instr_ready;
  logic       stall;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] alu_op;
  logic       load_a;
  logic       load_b;
  logic       busy;
  logic       done;
  logic       err;
  modport master (
    output instr_valid, instr_op, stall,
    input  instr_ready, sel_a, sel_b, alu_op, load_a, load_b, busy, done, err
  );
  modport slave (
    input  instr_valid, instr_op, stall,
    output instr_ready, sel_a, sel_b, alu_op, load_a, load_b, busy, done, err
  );
endinterface

// File: rtl/operand_seq_decode.sv
// operand_seq_decode: opcode to legality, step count and per-step datapath controls
module operand_seq_decode
  import operand_sequencer_pkg::*;
(
  input  logic [3:0] op,
  output logic       legal,
  output logic [1:0] nsteps,
  output step_t      step1,
  output step_t      step2
);
  always_comb begin
    legal = 1'b1;
    nsteps = 2'd1;
    step1 = '0;
    step2 = '0;
    case (op)
      OP_NOP:    nsteps = 2'd0;
      OP_ADD:    step1 = mk_step(SEL_REGA, SEL_REGA, ALU_ADD, 1'b1, 1'b0);
      OP_SUB:    step1 = mk_step(SEL_REGA, SEL_REGA, ALU_SUB, 1'b1, 1'b0);
      OP_INC:    step1 = mk_step(SEL_REGA, SEL_ONE, ALU_ADD, 1'b1, 1'b0);
      OP_CLRA:   step1 = mk_step(SEL_ZERO, SEL_ZERO, ALU_ADD, 1'b1, 1'b0);
      OP_MOVAB:  step1 = mk_step(SEL_REGA, SEL_ZERO, ALU_ADD, 1'b0, 1'b1);
      OP_DBL:    step1 = mk_step(SEL_REGA, SEL_REGB, ALU_ADD, 1'b1, 1'b0);
      OP_CLR2: begin
        nsteps = 2'd2;
        step1 = mk_step(SEL_ZERO, SEL_ZERO, ALU_ADD, 1'b1, 1'b0);
        step2 = mk_step(SEL_ZERO, SEL_ZERO, ALU_ADD, 1'b0, 1'b1);
      end
      OP_ADDINC: begin
        nsteps = 2'd2;
        step1 = mk_step(SEL_REGA, SEL_REGA, ALU_ADD, 1'b1, 1'b0);
        step2 = mk_step(SEL_REGA, SEL_ONE, ALU_ADD, 1'b1, 1'b0);
      end
      default: begin
        legal = 1'b0;
        nsteps = 2'd0;
      end
    endcase
  end
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: multi-step ALU operand/control sequencer driven by a 4-bit opcode
module operand_sequencer
  import operand_sequencer_pkg::*;
(
  input logic clk,
  input logic rst_n,
  operand_sequencer_if.slave bus
);
  state_t     state;
  logic [3:0] op_q;
  logic [3:0] dec_op;
  logic       legal;
  logic [1:0] nsteps;
  step_t      s1, s2, cur;
  logic       ready_q, busy_q, done_q, err_q;
  // Decode the live opcode in IDLE so err can be registered at accept time
  assign dec_op = (state == IDLE) ? bus.instr_op : op_q;
  operand_seq_decode u_dec (
    .op(dec_op),
    .legal(legal),
    .nsteps(nsteps),
    .step1(s1),
    .step2(s2)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      cur <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (bus.instr_valid) begin
          op_q <= bus.instr_op;
          state <= DECODE;
          err_q <= ~legal;
          ready_q <= 1'b0;
          busy_q <= 1'b1;
        end
        DECODE: if (!legal) begin
          state <= IDLE;
          ready_q <= 1'b1;
          busy_q <= 1'b0;
        end else if (nsteps == 2'd0) begin
          state <= FIN;
          done_q <= 1'b1;
        end else begin
          state <= EXEC1;
          cur <= s1;
        end
        EXEC1: if (!bus.stall) begin
          if (nsteps == 2'd2) begin
            state <= EXEC2;
            cur <= s2;
          end else begin
            state <= FIN;
            cur <= '0;
            done_q <= 1'b1;
          end
        end
        EXEC2: if (!bus.stall) begin
          state <= FIN;
          cur <= '0;
          done_q <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          ready_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cur <= '0;
          ready_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
  // Stall is a same-cycle input, so the load strobes are gated rather than registered
  assign bus.instr_ready = ready_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.sel_a = cur.sel_a;
  assign bus.sel_b = cur.sel_b;
  assign bus.alu_op = cur.alu_op;
  assign bus.load_a = cur.load_a & ~bus.stall;
  assign bus.load_b = cur.load_b & ~bus.stall;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed cycle-by-cycle checks of the operand sequencer
module tb_operand_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  operand_sequencer_if bus();
  operand_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [11:0] e(logic rdy, logic [1:0] sa, logic [1:0] sb, logic [1:0] alu,
                                    logic la, logic lb, logic bsy, logic dn, logic er);
    return {rdy, sa, sb, alu, la, lb, bsy, dn, er};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.instr_ready, bus.sel_a, bus.sel_b, bus.alu_op, bus.load_a, bus.load_b,
            bus.busy, bus.done, bus.err};
  endfunction

  task automatic go(input logic v, input logic [3:0] op, input logic st);
    @(posedge clk);
    #1;
    bus.instr_valid = v;
    bus.instr_op = op;
    bus.stall = st;
    #2;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = outs();
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  logic [11:0] idle_o, dec_o, fin_o, err_o;
  logic [3:0] t_op [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  logic [1:0] t_sa [6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
  logic [1:0] t_sb [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [1:0] t_al [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  logic       t_lb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    idle_o = e(1, 0, 0, 0, 0, 0, 0, 0, 0);
    dec_o  = e(0, 0, 0, 0, 0, 0, 1, 0, 0);
    fin_o  = e(0, 0, 0, 0, 0, 0, 1, 1, 0);
    err_o  = e(0, 0, 0, 0, 0, 0, 1, 0, 1);
    bus.instr_valid = 1'b0;
    bus.instr_op = 4'h0;
    bus.stall = 1'b0;
    go(0, 0, 0);
    go(0, 0, 0);
    chk("reset", idle_o);
    // ADD accepted on the very first edge after reset release
    go(1, 4'h1, 0);
    rst_n = 1'b1;
    chk("add_c0", idle_o);
    go(0, 4'hB, 0); chk("add_c1", dec_o);
    go(0, 4'h0, 0); chk("add_c2", e(0, 0, 0, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0); chk("add_c3", fin_o);
    // CLR2
    go(1, 4'h7, 0); chk("clr2_c0", idle_o);
    go(0, 4'h0, 0); chk("clr2_c1", dec_o);
    go(0, 4'h0, 0); chk("clr2_c2", e(0, 2, 2, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0); chk("clr2_c3", e(0, 2, 2, 0, 0, 1, 1, 0, 0));
    go(0, 4'h0, 0); chk("clr2_c4", fin_o);
    // INC stalled for cycles 2-4
    go(1, 4'h3, 0); chk("inc_c0", idle_o);
    go(0, 4'h0, 0); chk("inc_c1", dec_o);
    for (int c = 2; c <= 4; c++) begin
      go(0, 4'h0, 1); chk($sformatf("inc_stall_c%0d", c), e(0, 0, 1, 0, 0, 0, 1, 0, 0));
    end
    go(0, 4'h0, 0); chk("inc_c5", e(0, 0, 1, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0); chk("inc_c6", fin_o);
    // Illegal opcodes
    foreach (t_op[i]) begin end
    go(1, 4'hB, 0); chk("illB_c0", idle_o);
    go(0, 4'h0, 0); chk("illB_c1", err_o);
    go(0, 4'h0, 0); chk("illB_c2", idle_o);
    go(1, 4'hF, 0); chk("illF_c0", idle_o);
    go(0, 4'h0, 0); chk("illF_c1", err_o);
    go(0, 4'h0, 0); chk("illF_c2", idle_o);
    // ADDINC with reset asserted during step 1
    go(1, 4'h8, 0); chk("rst_c0", idle_o);
    go(0, 4'h0, 0); chk("rst_c1", dec_o);
    go(0, 4'h0, 0);
    rst_n = 1'b0;
    chk("rst_c2", e(0, 0, 0, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0);
    rst_n = 1'b1;
    chk("rst_c3", idle_o);
    go(0, 4'h0, 0); chk("rst_c4", idle_o);
    // Full ADDINC
    go(1, 4'h8, 0); chk("addinc_c0", idle_o);
    go(0, 4'h0, 0); chk("addinc_c1", dec_o);
    go(0, 4'h0, 0); chk("addinc_c2", e(0, 0, 0, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0); chk("addinc_c3", e(0, 0, 1, 0, 1, 0, 1, 0, 0));
    go(0, 4'h0, 0); chk("addinc_c4", fin_o);
    // Remaining one-step opcodes
    for (int i = 0; i < 6; i++) begin
      go(1, t_op[i], 0); chk($sformatf("op%0h_c0", t_op[i]), idle_o);
      go(0, 4'h0, 0); chk($sformatf("op%0h_c1", t_op[i]), dec_o);
      go(0, 4'h0, 0);
      chk($sformatf("op%0h_c2", t_op[i]), e(0, t_sa[i], t_sb[i], t_al[i], ~t_lb[i], t_lb[i], 1, 0, 0));
      go(0, 4'h0, 0); chk($sformatf("op%0h_c3", t_op[i]), fin_o);
    end
    // MOVAB then NOP back-to-back with instr_valid held high
    go(1, 4'h5, 0); chk("b2b_c0", idle_o);
    go(1, 4'h0, 0); chk("b2b_c1", dec_o);
    go(1, 4'h0, 0); chk("b2b_c2", e(0, 0, 2, 0, 0, 1, 1, 0, 0));
    go(1, 4'h0, 0); chk("b2b_c3", fin_o);
    go(1, 4'h0, 0); chk("b2b_c4", idle_o);
    go(0, 4'h0, 0); chk("b2b_c5", dec_o);
    go(0, 4'h0, 0); chk("b2b_c6", fin_o);
    go(0, 4'h0, 0); chk("b2b_c7", idle_o);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 The module SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  opcode offered
- instr_op  in  4  opcode
- instr_ready  out  1  sequencer can accept
- stall  in  1  freeze EXEC steps
- sel_a  out  2  operand-A mux select: 00 reg A, 01 const 1, 10 const 0, 11 reg B
- sel_b  out  2  operand-B mux select: 00 reg B, 01 const 1, 10 const 0, 11 reg A
- alu_op  out  2  00 ADD, 01 SUB, 10/11 reserved
- load_a  out  1  write ALU result to reg A
- load_b  out  1  write ALU result to reg B
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-opcode pulse

Function
REQ-003 States SHALL be IDLE, DECODE, EXEC1, EXEC2, FIN.
REQ-004 instr_ready SHALL be 1 only in IDLE; accept = instr_valid & instr_ready.
REQ-005 On accept, instr_op SHALL be latched and the state SHALL go to DECODE; instr_op changes after accept SHALL be ignored.
REQ-006 DECODE SHALL last one cycle and then go:
- legal 1- or 2-step op -> EXEC1
- NOP -> FIN
- illegal op -> IDLE, with err=1 in the DECODE cycle.
REQ-007 Opcode table (step1; step2):
- 0x0 NOP: no steps
- 0x1 ADD: sel 00/00, ADD, load_a
- 0x2 SUB: sel 00/00, SUB, load_a
- 0x3 INC: sel 00/01, ADD, load_a
- 0x4 CLRA: sel 10/10, ADD, load_a
- 0x5 MOVAB: sel 00/10, ADD, load_b
- 0x6 DBL: sel 00/11, ADD, load_a
- 0x7 CLR2: step1 sel 10/10, ADD, load_a; step2 sel 10/10, ADD, load_b
- 0x8 ADDINC: step1 as ADD; step2 as INC
- 0x9-0xF: illegal.
REQ-008 In EXEC1/EXEC2, sel_a, sel_b and alu_op SHALL show the step's values, and the step's load_* SHALL assert for exactly one non-stalled cycle.
REQ-009 In EXEC1 or EXEC2 with stall=1, the state SHALL hold, sel_a/sel_b/alu_op SHALL hold, and load_a=load_b=0.
REQ-010 After EXEC1, a 1-step op SHALL go to FIN and a 2-step op SHALL go to EXEC2; after EXEC2 the state SHALL go to FIN.
REQ-011 FIN SHALL assert done=1 for one cycle and return to IDLE; a new instruction SHALL be acceptable in the following cycle.
REQ-012 Latency, unstalled, with accept at cycle 0:
- 1-step op: load at cycle 2, done at cycle 3
- 2-step op: loads at cycles 2 and 3, done at cycle 4
- NOP: done at cycle 2
- illegal op: err at cycle 1, instr_ready=1 at cycle 2.
REQ-013 In IDLE, DECODE and FIN, sel_a=00, sel_b=00, alu_op=00 and load_a=load_b=0.
REQ-014 busy SHALL be 1 in DECODE, EXEC1, EXEC2 and FIN.
REQ-015 load_a and load_b SHALL never be 1 in the same cycle, and done and err SHALL never be 1 in the same cycle.

Reset
REQ-016 With rst_n=0 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 except instr_ready=1, including mid-operation; a pending load SHALL be dropped.
REQ-017 When reset is released, the first accept SHALL be possible on the first edge with rst_n=1.

Structure
REQ-018 A shared package SHALL hold the state encoding, the opcode constants, the sel_* constants (SEL_REGA, SEL_ONE, SEL_ZERO, SEL_REGB) and the alu_op constants.
REQ-019 A combinational sub-module, operand_seq_decode, SHALL map opcode to {legal, nsteps, step1 controls, step2 controls}.

Verification
REQ-020 Reset, then ADD (0x1) with no stall -> load_a=1, sel 00/00, alu 00 at cycle 2; done at cycle 3; no load_b.
REQ-021 CLR2 (0x7) -> cycle 2: load_a, sel 10/10; cycle 3: load_b, sel 10/10; done at cycle 4.
REQ-022 INC (0x3) with stall=1 for cycles 2-4 -> sel 00/01 held, no load during stall; load_a at cycle 5; done at cycle 6.
REQ-023 Opcode 0xB -> err=1 at cycle 1; no load or done; instr_ready=1 at cycle 2.
REQ-024 ADDINC (0x8) with rst_n=0 at cycle 2 -> all outputs 0 and instr_ready=1 on the next cycle; no step2 load; no done.
REQ-025 Back-to-back MOVAB then NOP, with instr_valid held high -> load_b at cycle 2, done at cycle 3, second accept at cycle 4, done at cycle 6.
